// File: rtl/led_meter_arbiter_if.sv
// Avalon-MM register port, codec sample stream and LED drive for the LED meter arbiter.
interface led_meter_arbiter_if #(
    parameter int unsigned LED_WIDTH = 10
) ();
    logic [1:0]           address;
    logic                 chipselect;
    logic                 write_n;
    logic [31:0]          writedata;
    logic [31:0]          readdata;
    logic                 sample_valid;
    logic [15:0]          sample_data;
    logic [LED_WIDTH-1:0] led_out;

    modport master (
        output address, chipselect, write_n, writedata, sample_valid, sample_data,
        input  readdata, led_out
    );

    modport slave (
        input  address, chipselect, write_n, writedata, sample_valid, sample_data,
        output readdata, led_out
    );
endinterface

// File: rtl/led_meter_arbiter.sv
// LED bar arbiter: software-owned manual pattern, log-scale VU meter with
// peak-hold/decay, and a mode select choosing manual, meter, overlay or freeze.
module led_meter_arbiter #(
    parameter int unsigned LED_WIDTH     = 10,
    parameter int unsigned DECAY_WIDTH   = 24,
    parameter int unsigned DEFAULT_DECAY = 2500000
) (
    input  logic                clk,
    input  logic                reset,
    led_meter_arbiter_if.slave  bus
);
    localparam int unsigned PEAK_W   = $clog2(LED_WIDTH + 1);
    localparam int unsigned MAG_W    = 15;
    localparam int unsigned STATUS_W = PEAK_W + LED_WIDTH;

    logic [LED_WIDTH-1:0]   manual_q;
    logic [1:0]             mode_q;
    logic [DECAY_WIDTH-1:0] decay_q;
    logic [PEAK_W-1:0]      lvl_q;
    logic                   lvl_valid_q;
    logic [PEAK_W-1:0]      peak_q;
    logic [DECAY_WIDTH-1:0] cnt_q;
    logic [LED_WIDTH-1:0]   led_q;

    logic                   wr_c;
    logic                   clear_peak_c;
    logic [MAG_W-1:0]       mag_c;
    logic [PEAK_W-1:0]      level_c;
    logic [DECAY_WIDTH-1:0] reload_c;
    logic [LED_WIDTH-1:0]   meter_bar_c;
    logic [31:0]            rdata_c;
    logic                   unused_wdata;

    assign wr_c         = bus.chipselect && !bus.write_n;
    assign clear_peak_c = wr_c && (bus.address == 2'd1) && bus.writedata[2];
    // A zero decay reload would stall the count at zero; treat it as one.
    assign reload_c     = (decay_q == '0) ? DECAY_WIDTH'(1) : decay_q;
    assign unused_wdata = ^bus.writedata[31:DECAY_WIDTH];

    // Magnitude of the sample; -32768 saturates to 32767.
    always_comb begin
        mag_c = bus.sample_data[MAG_W-1:0];
        if (bus.sample_data[15]) begin
            if (bus.sample_data == 16'h8000) begin
                mag_c = 15'h7FFF;
            end else begin
                mag_c = MAG_W'(-bus.sample_data);
            end
        end
    end

    // Log-scale level: MSB index minus 4, zero below 32, clipped to LED_WIDTH.
    always_comb begin
        level_c = '0;
        for (int i = 5; i < int'(MAG_W); i++) begin
            if (mag_c[i]) begin
                level_c = ((i - 4) > int'(LED_WIDTH)) ? PEAK_W'(LED_WIDTH) : PEAK_W'(i - 4);
            end
        end
    end

    // Thermometer bar: the low peak_q LEDs lit.
    always_comb begin
        meter_bar_c = '0;
        for (int i = 0; i < int'(LED_WIDTH); i++) begin
            meter_bar_c[i] = (PEAK_W'(i) < peak_q);
        end
    end

    // Zero-wait-state read mux; does not depend on chipselect.
    always_comb begin
        rdata_c = '0;
        case (bus.address)
            2'd0:    rdata_c = 32'(manual_q);
            2'd1:    rdata_c = 32'(mode_q);
            2'd2:    rdata_c = 32'(decay_q);
            default: rdata_c = 32'(STATUS_W'({peak_q, led_q}));
        endcase
    end

    assign bus.readdata = rdata_c;
    assign bus.led_out  = led_q;

    // Software registers; writes to STATUS are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            manual_q <= '0;
            mode_q   <= 2'b00;
            decay_q  <= DECAY_WIDTH'(DEFAULT_DECAY);
        end else if (wr_c) begin
            case (bus.address)
                2'd0:    manual_q <= bus.writedata[LED_WIDTH-1:0];
                2'd1:    mode_q   <= bus.writedata[1:0];
                2'd2:    decay_q  <= bus.writedata[DECAY_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Stage 1: register the level of each valid sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q       <= '0;
            lvl_valid_q <= 1'b0;
        end else begin
            lvl_valid_q <= bus.sample_valid;
            if (bus.sample_valid) begin
                lvl_q <= level_c;
            end
        end
    end

    // Stage 2: peak hold with decay; clear wins, then a new peak, then decay.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
            cnt_q  <= DECAY_WIDTH'(DEFAULT_DECAY);
        end else if (clear_peak_c) begin
            peak_q <= '0;
            cnt_q  <= reload_c;
        end else if (lvl_valid_q && (lvl_q >= peak_q)) begin
            peak_q <= lvl_q;
            cnt_q  <= reload_c;
        end else if (cnt_q == '0) begin
            if (peak_q != '0) begin
                peak_q <= peak_q - PEAK_W'(1);
            end
            cnt_q <= reload_c;
        end else begin
            cnt_q <= cnt_q - DECAY_WIDTH'(1);
        end
    end

    // LED source select; freeze holds the current pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            case (mode_q)
                2'b00:   led_q <= manual_q;
                2'b01:   led_q <= meter_bar_c;
                2'b10:   led_q <= manual_q | meter_bar_c;
                default: led_q <= led_q;
            endcase
        end
    end
endmodule

// File: tb/tb_led_meter_arbiter.sv
// Self-checking bench for led_meter_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_led_meter_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    led_meter_arbiter_if bus_if ();

    led_meter_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [9:0]  m_manual;
    logic [1:0]  m_mode;
    logic [23:0] m_decay;
    int          m_peak;
    int          m_cnt;
    logic        m_pend_v;
    int          m_pend_lvl;
    logic [9:0]  m_led;

    function automatic int level_of(logic [15:0] s);
        int v;
        int a;
        int m;
        v = int'($signed(s));
        a = (v < 0) ? -v : v;
        if (a > 32767) a = 32767;
        if (a < 32) return 0;
        m = 0;
        while ((a >> (m + 1)) != 0) m++;
        return ((m - 4) > 10) ? 10 : (m - 4);
    endfunction

    function automatic logic [9:0] bar(int p);
        return 10'((32'd1 << p) - 32'd1);
    endfunction

    function automatic logic [31:0] exp_rd(logic [1:0] a);
        case (a)
            2'd0:    return {22'd0, m_manual};
            2'd1:    return {30'd0, m_mode};
            2'd2:    return {8'd0, m_decay};
            default: return {18'd0, 4'(m_peak), m_led};
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic wr;
        logic clr;
        int   reload;
        int   np;
        int   nc;
        wr     = bus_if.chipselect && !bus_if.write_n;
        clr    = wr && (bus_if.address == 2'd1) && bus_if.writedata[2];
        reload = (m_decay == 24'd0) ? 1 : int'(m_decay);
        np     = m_peak;
        nc     = m_cnt;
        if (clr) begin
            np = 0; nc = reload;
        end else if (m_pend_v && m_pend_lvl >= m_peak) begin
            np = m_pend_lvl; nc = reload;
        end else if (m_cnt == 0) begin
            if (m_peak > 0) np = m_peak - 1;
            nc = reload;
        end else begin
            nc = m_cnt - 1;
        end
        if (reset) begin
            m_manual   <= '0;
            m_mode     <= '0;
            m_decay    <= 24'd2500000;
            m_peak     <= 0;
            m_cnt      <= 2500000;
            m_pend_v   <= 1'b0;
            m_pend_lvl <= 0;
            m_led      <= '0;
        end else begin
            m_peak     <= np;
            m_cnt      <= nc;
            m_pend_v   <= bus_if.sample_valid;
            m_pend_lvl <= level_of(bus_if.sample_data);
            case (m_mode)
                2'd0:    m_led <= m_manual;
                2'd1:    m_led <= bar(m_peak);
                2'd2:    m_led <= m_manual | bar(m_peak);
                default: m_led <= m_led;
            endcase
            if (wr) begin
                case (bus_if.address)
                    2'd0:    m_manual <= bus_if.writedata[9:0];
                    2'd1:    m_mode   <= bus_if.writedata[1:0];
                    2'd2:    m_decay  <= bus_if.writedata[23:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        cyc();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic send_sample(input logic [15:0] s);
        bus_if.sample_valid = 1'b1;
        bus_if.sample_data  = s;
        cyc();
        bus_if.sample_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus_if.address = a;
        #1;
        d = bus_if.readdata;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp [4];
        exp[0] = 32'd0; exp[1] = 32'd0; exp[2] = 32'd2500000; exp[3] = 32'd0;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), d);
            checks++;
            if (d !== exp[i]) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, d, exp[i]);
            end
        end
        checks++;
        if (bus_if.led_out !== 10'h000) begin
            failures++;
            $display("FAIL reset_led got=%h exp=%h", bus_if.led_out, 10'h000);
        end
    endtask

    task automatic test_manual();
        logic [31:0] d;
        bus_write(2'd0, 32'h2A5);
        cyc();
        checks++;
        if (bus_if.led_out !== 10'h2A5) begin
            failures++;
            $display("FAIL manual_led got=%h exp=%h", bus_if.led_out, 10'h2A5);
        end
        read_reg(2'd3, d);
        checks++;
        if (d !== 32'h000002A5) begin
            failures++;
            $display("FAIL manual_status got=%h exp=%h", d, 32'h000002A5);
        end
    endtask

    task automatic test_decay();
        logic [31:0] d;
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'd4);
        send_sample(16'h4000);
        cyc(); cyc();
        checks++;
        if (bus_if.led_out !== 10'h3FF) begin
            failures++;
            $display("FAIL decay_led_full got=%h exp=%h", bus_if.led_out, 10'h3FF);
        end
        cyc(); cyc(); cyc();
        read_reg(2'd3, d);
        checks++;
        if (d[13:10] !== 4'd10) begin
            failures++;
            $display("FAIL decay_hold got=%0d exp=%0d", d[13:10], 10);
        end
        cyc();
        read_reg(2'd3, d);
        checks++;
        if (d[13:10] !== 4'd9) begin
            failures++;
            $display("FAIL decay_first_step got=%0d exp=%0d", d[13:10], 9);
        end
        for (int i = 0; i < 50; i++) begin
            cyc();
            read_reg(2'd3, d);
            checks++;
            if (d !== exp_rd(2'd3)) begin
                failures++;
                $display("FAIL decay_walk cyc=%0d got=%h exp=%h", i, d, exp_rd(2'd3));
            end
        end
        checks++;
        if (d[13:10] !== 4'd0) begin
            failures++;
            $display("FAIL decay_floor got=%0d exp=%0d", d[13:10], 0);
        end
    endtask

    task automatic test_level_edges();
        logic [31:0] d;
        logic [15:0] smp [3];
        smp[0] = 16'h8000; smp[1] = 16'd31; smp[2] = 16'd32;
        bus_write(2'd2, 32'd1000);
        for (int i = 0; i < 3; i++) begin
            send_sample(smp[i]);
            cyc();
            read_reg(2'd3, d);
            checks++;
            if (d[13:10] !== 4'd10) begin
                failures++;
                $display("FAIL level_edge s=%h got=%0d exp=%0d", smp[i], d[13:10], 10);
            end
        end
        bus_write(2'd1, 32'h5);
        read_reg(2'd3, d);
        checks++;
        if (d[13:10] !== 4'd0) begin
            failures++;
            $display("FAIL clear_peak got=%0d exp=%0d", d[13:10], 0);
        end
        read_reg(2'd1, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL ctrl_readback got=%h exp=%h", d, 32'h1);
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] d;
        send_sample(16'h4000);
        bus_write(2'd1, 32'h5);
        read_reg(2'd3, d);
        checks++;
        if (d[13:10] !== 4'd0) begin
            failures++;
            $display("FAIL collision_peak got=%0d exp=%0d", d[13:10], 0);
        end
        cyc();
        read_reg(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL collision_after got=%h exp=%h", d, 32'h0);
        end
    endtask

    task automatic test_overlay_freeze();
        logic [31:0] d;
        bus_write(2'd1, 32'h2);
        bus_write(2'd0, 32'h200);
        send_sample(16'd200);
        cyc(); cyc();
        checks++;
        if (bus_if.led_out !== 10'h207) begin
            failures++;
            $display("FAIL overlay_led got=%h exp=%h", bus_if.led_out, 10'h207);
        end
        bus_write(2'd1, 32'h3);
        for (int i = 0; i < 4; i++) send_sample(16'h7FFF);
        cyc(); cyc(); cyc();
        checks++;
        if (bus_if.led_out !== 10'h207) begin
            failures++;
            $display("FAIL freeze_led got=%h exp=%h", bus_if.led_out, 10'h207);
        end
        read_reg(2'd3, d);
        checks++;
        if (d !== 32'h00002A07) begin
            failures++;
            $display("FAIL freeze_status got=%h exp=%h", d, 32'h00002A07);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] exp [4];
        exp[0] = 32'd0; exp[1] = 32'd0; exp[2] = 32'd2500000; exp[3] = 32'd0;
        bus_write(2'd2, 32'd4);
        bus_write(2'd1, 32'h1);
        send_sample(16'h4000);
        cyc(); cyc(); cyc();
        send_sample(16'h4000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc(); cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), d);
            checks++;
            if (d !== exp[i]) begin
                failures++;
                $display("FAIL midreset_reg%0d got=%h exp=%h", i, d, exp[i]);
            end
        end
        send_sample(16'h4000);
        cyc();
        read_reg(2'd3, d);
        checks++;
        if (d !== 32'h00002800) begin
            failures++;
            $display("FAIL postreset_sample got=%h exp=%h", d, 32'h00002800);
        end
    endtask

    task automatic test_random();
        logic [31:0] wd;
        logic [1:0]  wa;
        for (int i = 0; i < 3000; i++) begin
            reset               = ($urandom_range(0, 499) == 0);
            bus_if.sample_valid = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) begin
                bus_if.sample_data = 16'($urandom);
            end else begin
                bus_if.sample_data = 16'($urandom_range(0, 64));
                if ($urandom_range(0, 1) == 1) bus_if.sample_data = -bus_if.sample_data;
            end
            wa = 2'($urandom_range(0, 3));
            case (wa)
                2'd1:    wd = 32'($urandom_range(0, 7)) | ($urandom & 32'hFFFF_FFF8);
                2'd2:    wd = 32'($urandom_range(0, 6)) | ($urandom & 32'hFF00_0000);
                default: wd = $urandom;
            endcase
            bus_if.address    = wa;
            bus_if.writedata  = wd;
            bus_if.chipselect = $urandom_range(0, 3) == 0;
            bus_if.write_n    = !($urandom_range(0, 1) == 1);
            cyc();
            checks++;
            if (bus_if.led_out !== m_led) begin
                failures++;
                $display("FAIL rand_led cyc=%0d got=%h exp=%h", i, bus_if.led_out, m_led);
            end
            #1;
            checks++;
            if (bus_if.readdata !== exp_rd(bus_if.address)) begin
                failures++;
                $display("FAIL rand_rd cyc=%0d addr=%0d got=%h exp=%h", i, bus_if.address,
                         bus_if.readdata, exp_rd(bus_if.address));
            end
        end
        reset               = 1'b0;
        bus_if.sample_valid = 1'b0;
        bus_if.chipselect   = 1'b0;
        bus_if.write_n      = 1'b1;
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        reset               = 1'b1;
        bus_if.address      = '0;
        bus_if.chipselect   = 1'b0;
        bus_if.write_n      = 1'b1;
        bus_if.writedata    = '0;
        bus_if.sample_valid = 1'b0;
        bus_if.sample_data  = '0;
        test_reset();
        test_manual();
        test_decay();
        test_level_edges();
        test_clear_collision();
        test_overlay_freeze();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_meter_arbiter.md
Name: led_meter_arbiter

Overview:
- Owns the 10-LED bar and shares it between two requesters: Nios software, through an Avalon-MM slave, and a hardware audio VU meter fed by the codec sample stream.
- The meter computes a log-scale bar level per sample and applies peak-hold with a programmable decay.
- A software-selected mode chooses the LED source: manual, meter, overlay or freeze.

Parameters:
- LED_WIDTH, 10, LED count; bar levels 0..LED_WIDTH.
- DECAY_WIDTH, 24, width of the decay reload register and the decay counter.
- DEFAULT_DECAY, 2500000, reset value of the decay reload (50 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational, zero wait states
- sample_valid  in  1  one-cycle strobe; sample_data is valid this cycle
- sample_data  in  16  signed two's-complement audio sample
- led_out  out  LED_WIDTH  registered LED drive

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state changes on the rising edge of clk.
- Register map; a write occurs when chipselect=1 and write_n=0:
  - addr0 MANUAL: RW, bits [9:0].
  - addr1 CTRL: bits [1:0] = mode, RW. Bit 2 = clear_peak, write-1 pulse, reads 0.
  - addr2 DECAY: RW, bits [DECAY_WIDTH-1:0].
  - addr3 STATUS: RO, {18'b0, peak[3:0], led_out[9:0]}. Writes to addr3 are ignored.
  - Unused readdata bits read 0. readdata ignores chipselect.
- Reset values: MANUAL=0, mode=00, DECAY=DEFAULT_DECAY, peak=0, decay counter=DEFAULT_DECAY, level stage=0, led_out=0.
- Stage 1, level (registered on sample_valid):
  - a = |sample_data|; -32768 saturates to 32767.
  - m = index of the MSB of a.
  - level = 0 if a<32, otherwise min(m-4, 10). Examples: a=32 -> 1; a>=16384 -> 10.
  - lvl_valid pulses one cycle after sample_valid.
- Stage 2, peak hold (priority order per cycle):
  1. clear_peak write: peak<=0, counter<=DECAY.
  2. lvl_valid and level>=peak: peak<=level, counter<=DECAY.
  3. Otherwise, if counter==0: if peak>0 then peak<=peak-1; counter<=DECAY.
  4. Otherwise counter<=counter-1.
- DECAY=0 behaves as 1: peak drops one step every other cycle at most.
- A DECAY write takes effect at the next counter reload; the current count is not disturbed.
- meter_bar = thermometer of peak: the low `peak` bits are 1, e.g. peak=3 -> 0x007.
- led_out, registered, one cycle after its source changes:
  - mode 00: MANUAL.
  - mode 01: meter_bar.
  - mode 10: MANUAL | meter_bar.
  - mode 11: hold current led_out (freeze). Peak tracking continues underneath.
- Latency: sample_valid at cycle N -> peak updated at N+2 -> led_out updated at N+3.
- Back-to-back sample_valid every cycle is fully supported, no drops.
- A register write and a sample in the same cycle are independent, except for the clear_peak priority above.
- Reset mid-decay or mid-pipeline discards the in-flight level; the first post-reset sample is processed normally.

Test Plan:
- Reset, then read addr0..3 -> 0, 0, 2500000, 0; led_out=0x000.
- Mode 00, write MANUAL=0x2A5 -> led_out=0x2A5 one cycle later; STATUS reads 0x000002A5.
- Mode 01, DECAY=4:
  - one sample 0x4000 -> peak=10 and led_out=0x3FF at +3 cycles.
  - No further samples -> peak=9 after 5 cycles (counter 4..0), then one step per 5 cycles down to 0.
- Mode 01, samples -32768, then 31, then 32:
  - -32768 -> level 10.
  - 31 -> level 0, no peak change.
  - 32 -> level 1, no peak change (1<10).
  - Write CTRL=0x5 -> peak=0 next cycle.
  - Same-cycle clear_peak plus lvl_valid -> peak=0, not the sample level.
- Mode 10, MANUAL=0x200, peak=3 -> led_out=0x207. Switch to mode 11, then drive loud samples -> led_out stays 0x207 while STATUS peak rises to 10.
- Assert reset while the decay counter is mid-count and lvl_valid is pending -> all state returns to reset values, no stale peak update follows.
